// File: rtl/board_controller.sv
// Tic-tac-toe board owner: takes human and CPU moves over valid/ready and validates them.
// Writes legal moves, scores the board after every move and exports it 2 bits per cell.
module board_controller #(
  parameter logic [1:0] CELL_X      = 2'd0,
  parameter logic [1:0] CELL_O      = 2'd1,
  parameter logic [1:0] CELL_EMPTY  = 2'd2,
  parameter int         CPU_TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        human_first,
  input  logic        p_valid,
  input  logic [3:0]  p_coord,
  output logic        p_ready,
  output logic        cpu_req,
  input  logic        cpu_valid,
  input  logic [3:0]  cpu_coord,
  output logic [17:0] matriz,
  output logic        turn,
  output logic        move_err,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam int          TW          = $clog2(CPU_TIMEOUT + 1);
  localparam logic [17:0] EMPTY_BOARD = {9{CELL_EMPTY}};

  typedef enum logic [2:0] {IDLE, HUMAN, CPU, CHECK, OVER} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [17:0]     r_board;
  logic [3:0]      r_moveCount;
  logic [TW-1:0]   r_timeout;
  logic [1:0]      r_winner;
  logic [1:0]      r_lastMark;
  logic            r_moveErr;

  logic            w_humanLegal;
  logic            w_cpuLegal;
  logic            w_humanAccept;
  logic            w_humanReject;
  logic            w_cpuAccept;
  logic            w_cpuReject;
  logic            w_timeoutHit;
  logic            w_lineWin;
  logic            w_boardFull;
  logic [3:0]      w_moveCoord;
  logic [1:0]      w_moveMark;

  // Out-of-range indices read back as code 3, which never matches EMPTY.
  function automatic logic [1:0] cellAt(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] v;
    v = 2'b11;
    for (int i = 0; i < 9; i++)
      if (idx == 4'(i)) v = b[2*i +: 2];
    return v;
  endfunction

  function automatic logic hasLine(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] h;
    for (int i = 0; i < 9; i++) h[i] = (b[2*i +: 2] == m);
    return (h[0] & h[1] & h[2]) | (h[3] & h[4] & h[5]) | (h[6] & h[7] & h[8]) |
           (h[0] & h[3] & h[6]) | (h[1] & h[4] & h[7]) | (h[2] & h[5] & h[8]) |
           (h[0] & h[4] & h[8]) | (h[2] & h[4] & h[6]);
  endfunction

  assign w_humanLegal  = (p_coord <= 4'd8) && (cellAt(r_board, p_coord) == CELL_EMPTY);
  assign w_cpuLegal    = (cpu_coord <= 4'd8) && (cellAt(r_board, cpu_coord) == CELL_EMPTY);
  assign w_humanAccept = (r_state == HUMAN) && p_valid && w_humanLegal;
  assign w_humanReject = (r_state == HUMAN) && p_valid && !w_humanLegal;
  assign w_cpuAccept   = (r_state == CPU) && cpu_valid && w_cpuLegal;
  assign w_cpuReject   = (r_state == CPU) && cpu_valid && !w_cpuLegal;
  // The counter reaches CPU_TIMEOUT on this edge, so cpu_req is high CPU_TIMEOUT cycles.
  assign w_timeoutHit  = (r_state == CPU) && !w_cpuAccept && (r_timeout == TW'(CPU_TIMEOUT - 1));
  assign w_lineWin     = hasLine(r_board, r_lastMark);
  assign w_boardFull   = (r_moveCount == 4'd9);
  assign w_moveCoord   = w_humanAccept ? p_coord : cpu_coord;
  assign w_moveMark    = w_humanAccept ? CELL_X : CELL_O;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    p_ready     = 1'b0;
    cpu_req     = 1'b0;
    turn        = 1'b0;
    game_over   = 1'b0;
    case (r_state)
      IDLE:  w_nextState = IDLE;
      HUMAN: begin
        p_ready = 1'b1;
        if (w_humanAccept) w_nextState = CHECK;
      end
      CPU: begin
        cpu_req = 1'b1;
        turn    = 1'b1;
        if (w_cpuAccept)       w_nextState = CHECK;
        else if (w_timeoutHit) w_nextState = OVER;
      end
      CHECK: begin
        if (w_lineWin || w_boardFull)  w_nextState = OVER;
        else if (r_lastMark == CELL_X) w_nextState = CPU;
        else                            w_nextState = HUMAN;
      end
      OVER:    game_over   = 1'b1;
      default: w_nextState = IDLE;
    endcase
    if (start) w_nextState = human_first ? HUMAN : CPU;
  end

  // A new game clears exactly what reset clears, except the state register.
  always_ff @(posedge clock) begin
    if (reset || start) begin
      r_board     <= EMPTY_BOARD;
      r_moveCount <= 4'd0;
      r_timeout   <= '0;
      r_winner    <= 2'd3;
      r_lastMark  <= CELL_X;
      r_moveErr   <= 1'b0;
    end else begin
      r_moveErr <= w_humanReject | w_cpuReject;
      r_timeout <= (r_state == CPU) ? r_timeout + TW'(1) : '0;
      if (w_humanAccept || w_cpuAccept) begin
        for (int i = 0; i < 9; i++)
          if (w_moveCoord == 4'(i)) r_board[2*i +: 2] <= w_moveMark;
        r_moveCount <= r_moveCount + 4'd1;
        r_lastMark  <= w_moveMark;
      end
      // A line on the ninth move must win over the full-board draw.
      if (r_state == CHECK) begin
        if (w_lineWin)        r_winner <= (r_lastMark == CELL_X) ? 2'd0 : 2'd1;
        else if (w_boardFull) r_winner <= 2'd2;
      end
      if (w_timeoutHit) r_winner <= 2'd0;
    end
  end

  assign matriz   = r_board;
  assign winner   = r_winner;
  assign move_err = r_moveErr;

endmodule

// File: tb/tb_board_controller.sv
// Directed self-checking bench for board_controller: every expected value is hand-computed
// or derived from a small board model kept by the bench.
module tb_board_controller;

  logic        clock = 1'b0;
  logic        reset, start, human_first, p_valid, cpu_valid;
  logic [3:0]  p_coord, cpu_coord;
  logic        p_ready, cpu_req, turn, move_err, game_over;
  logic [17:0] matriz;
  logic [1:0]  winner;

  int vecCount  = 0;
  int missCount = 0;
  logic [17:0] expBoard;

  localparam logic [17:0] EMPTY = 18'h2AAAA;

  board_controller dut (
    .clock(clock), .reset(reset), .start(start), .human_first(human_first),
    .p_valid(p_valid), .p_coord(p_coord), .p_ready(p_ready), .cpu_req(cpu_req),
    .cpu_valid(cpu_valid), .cpu_coord(cpu_coord), .matriz(matriz), .turn(turn),
    .move_err(move_err), .game_over(game_over), .winner(winner)
  );

  always #5 clock = ~clock;

  // Step one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [17:0] setCell(input logic [17:0] b, input int idx, input logic [1:0] m);
    logic [17:0] r;
    r = b;
    r[2*idx +: 2] = m;
    return r;
  endfunction

  task automatic doStart(input logic hf);
    start = 1'b1; human_first = hf;
    tick;
    start = 1'b0;
    expBoard = EMPTY;
  endtask

  // Offer a legal human move, then let the CHECK cycle pass.
  task automatic playHuman(input int c);
    p_valid = 1'b1; p_coord = 4'(c);
    tick;
    p_valid = 1'b0;
    expBoard = setCell(expBoard, c, 2'd0);
    tick;
  endtask

  task automatic playCpu(input int c);
    cpu_valid = 1'b1; cpu_coord = 4'(c);
    tick;
    cpu_valid = 1'b0;
    expBoard = setCell(expBoard, c, 2'd1);
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    vecCount++;
    if (matriz !== EMPTY) begin missCount++; $display("[TB] FAIL reset_board: got %h want %h", matriz, EMPTY); end
    vecCount++;
    if (winner !== 2'd3) begin missCount++; $display("[TB] FAIL reset_winner: got %0d want 3", winner); end
    vecCount++;
    if ({p_ready, cpu_req, turn, move_err, game_over} !== 5'b0) begin
      missCount++; $display("[TB] FAIL reset_flags: got %b want 00000", {p_ready, cpu_req, turn, move_err, game_over});
    end
    // IDLE must ignore both move paths.
    p_valid = 1'b1; p_coord = 4'd0; cpu_valid = 1'b1; cpu_coord = 4'd1;
    tick;
    p_valid = 1'b0; cpu_valid = 1'b0;
    vecCount++;
    if (matriz !== EMPTY || move_err !== 1'b0) begin
      missCount++; $display("[TB] FAIL idle_ignore: board %h err %b want %h err 0", matriz, move_err, EMPTY);
    end
  endtask

  task automatic test_start;
    doStart(1'b1);
    vecCount++;
    if (p_ready !== 1'b1 || turn !== 1'b0) begin
      missCount++; $display("[TB] FAIL start_ready: p_ready %b turn %b want 1 0", p_ready, turn);
    end
    vecCount++;
    if (matriz !== EMPTY || winner !== 2'd3) begin
      missCount++; $display("[TB] FAIL start_board: board %h winner %0d want %h 3", matriz, winner, EMPTY);
    end
  endtask

  task automatic test_human_win;
    doStart(1'b1);
    p_valid = 1'b1; p_coord = 4'd4;
    tick;
    p_valid = 1'b0;
    vecCount++;
    if (matriz !== 18'h2A8AA) begin missCount++; $display("[TB] FAIL first_move_board: got %h want 2a8aa", matriz); end
    vecCount++;
    if (p_ready !== 1'b0 || cpu_req !== 1'b0) begin
      missCount++; $display("[TB] FAIL check_cycle_quiet: p_ready %b cpu_req %b want 0 0", p_ready, cpu_req);
    end
    tick;
    vecCount++;
    if (cpu_req !== 1'b1 || turn !== 1'b1) begin
      missCount++; $display("[TB] FAIL cpu_req_latency: cpu_req %b turn %b want 1 1", cpu_req, turn);
    end
    expBoard = setCell(EMPTY, 4, 2'd0);
    playCpu(0); playHuman(3); playCpu(8); playHuman(5);
    vecCount++;
    if (game_over !== 1'b1 || winner !== 2'd0) begin
      missCount++; $display("[TB] FAIL human_win: game_over %b winner %0d want 1 0", game_over, winner);
    end
    vecCount++;
    if (matriz !== expBoard) begin missCount++; $display("[TB] FAIL human_win_board: got %h want %h", matriz, expBoard); end
    // Moves in OVER are dropped silently.
    p_valid = 1'b1; p_coord = 4'd1; cpu_valid = 1'b1; cpu_coord = 4'd2;
    tick;
    p_valid = 1'b0; cpu_valid = 1'b0;
    vecCount++;
    if (move_err !== 1'b0 || matriz !== expBoard || winner !== 2'd0) begin
      missCount++; $display("[TB] FAIL over_hold: err %b board %h winner %0d want 0 %h 0", move_err, matriz, winner, expBoard);
    end
  endtask

  task automatic test_illegal;
    int badH[4] = '{4, 0, 9, 15};
    int badC[3] = '{4, 1, 12};
    doStart(1'b1);
    playHuman(4); playCpu(0);
    foreach (badH[i]) begin
      p_valid = 1'b1; p_coord = 4'(badH[i]);
      tick;
      p_valid = 1'b0;
      vecCount++;
      if (move_err !== 1'b1 || p_ready !== 1'b1 || matriz !== expBoard) begin
        missCount++; $display("[TB] FAIL human_reject_%0d: err %b ready %b board %h want 1 1 %h", badH[i], move_err, p_ready, matriz, expBoard);
      end
      tick;
      vecCount++;
      if (move_err !== 1'b0) begin missCount++; $display("[TB] FAIL err_pulse_width_%0d: got %b want 0", badH[i], move_err); end
    end
    cpu_valid = 1'b1; cpu_coord = 4'd1;
    tick;
    cpu_valid = 1'b0;
    vecCount++;
    if (move_err !== 1'b0 || matriz !== expBoard) begin
      missCount++; $display("[TB] FAIL cpu_out_of_turn: err %b board %h want 0 %h", move_err, matriz, expBoard);
    end
    playHuman(1);
    foreach (badC[i]) begin
      cpu_valid = 1'b1; cpu_coord = 4'(badC[i]);
      tick;
      cpu_valid = 1'b0;
      vecCount++;
      if (move_err !== 1'b1 || cpu_req !== 1'b1 || matriz !== expBoard) begin
        missCount++; $display("[TB] FAIL cpu_reject_%0d: err %b req %b board %h want 1 1 %h", badC[i], move_err, cpu_req, matriz, expBoard);
      end
    end
    p_valid = 1'b1; p_coord = 4'd2;
    tick;
    p_valid = 1'b0;
    vecCount++;
    if (move_err !== 1'b0 || matriz !== expBoard) begin
      missCount++; $display("[TB] FAIL human_out_of_turn: err %b board %h want 0 %h", move_err, matriz, expBoard);
    end
    playCpu(2);
    vecCount++;
    if (matriz !== expBoard || p_ready !== 1'b1) begin
      missCount++; $display("[TB] FAIL cpu_retry_accept: board %h ready %b want %h 1", matriz, p_ready, expBoard);
    end
  endtask

  task automatic test_cpu_win;
    doStart(1'b0);
    playCpu(0); playHuman(3); playCpu(1); playHuman(4);
    vecCount++;
    if (winner !== 2'd3 || game_over !== 1'b0) begin
      missCount++; $display("[TB] FAIL cpu_win_early: winner %0d game_over %b want 3 0", winner, game_over);
    end
    playCpu(2);
    vecCount++;
    if (winner !== 2'd1 || game_over !== 1'b1 || matriz !== expBoard) begin
      missCount++; $display("[TB] FAIL cpu_win: winner %0d over %b board %h want 1 1 %h", winner, game_over, matriz, expBoard);
    end
  endtask

  task automatic test_draw;
    int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    doStart(1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) playHuman(seq[i]);
      else            playCpu(seq[i]);
    end
    vecCount++;
    if (winner !== 2'd3 || p_ready !== 1'b1) begin
      missCount++; $display("[TB] FAIL draw_before_last: winner %0d ready %b want 3 1", winner, p_ready);
    end
    playHuman(seq[8]);
    vecCount++;
    if (winner !== 2'd2 || game_over !== 1'b1) begin
      missCount++; $display("[TB] FAIL draw_result: winner %0d game_over %b want 2 1", winner, game_over);
    end
    vecCount++;
    if (matriz !== 18'h01504) begin missCount++; $display("[TB] FAIL draw_board: got %h want 01504", matriz); end
  endtask

  task automatic test_ninth_win;
    int seq[9] = '{0, 1, 2, 3, 4, 5, 7, 6, 8};
    doStart(1'b1);
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) playHuman(seq[i]);
      else            playCpu(seq[i]);
    end
    vecCount++;
    if (winner !== 2'd0 || game_over !== 1'b1 || matriz !== expBoard) begin
      missCount++; $display("[TB] FAIL ninth_move_win: winner %0d over %b board %h want 0 1 %h", winner, game_over, matriz, expBoard);
    end
  endtask

  task automatic test_start_override;
    doStart(1'b1);
    playHuman(4); playCpu(0);
    start = 1'b1; human_first = 1'b1; p_valid = 1'b1; p_coord = 4'd8;
    tick;
    start = 1'b0; p_valid = 1'b0;
    vecCount++;
    if (matriz !== EMPTY || p_ready !== 1'b1 || move_err !== 1'b0 || winner !== 2'd3) begin
      missCount++; $display("[TB] FAIL start_beats_move: board %h ready %b err %b winner %0d want %h 1 0 3", matriz, p_ready, move_err, winner, EMPTY);
    end
    tick;
    vecCount++;
    if (matriz !== EMPTY) begin missCount++; $display("[TB] FAIL start_move_dropped: got %h want %h", matriz, EMPTY); end
  endtask

  task automatic test_reset_midgame;
    doStart(1'b0);
    playCpu(4); playHuman(0);
    cpu_valid = 1'b1; cpu_coord = 4'd8; reset = 1'b1;
    tick;
    reset = 1'b0;
    vecCount++;
    if (matriz !== EMPTY || cpu_req !== 1'b0 || winner !== 2'd3 || game_over !== 1'b0) begin
      missCount++; $display("[TB] FAIL reset_midgame: board %h req %b winner %0d over %b want %h 0 3 0", matriz, cpu_req, winner, game_over, EMPTY);
    end
    tick;
    cpu_valid = 1'b0;
    vecCount++;
    if (matriz !== EMPTY || move_err !== 1'b0) begin
      missCount++; $display("[TB] FAIL reset_then_idle: board %h err %b want %h 0", matriz, move_err, EMPTY);
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    doStart(1'b0);
    while (cpu_req === 1'b1 && n < 2000) begin
      n++;
      tick;
    end
    vecCount++;
    if (n != 1023) begin missCount++; $display("[TB] FAIL timeout_cycles: cpu_req high %0d cycles want 1023", n); end
    vecCount++;
    if (game_over !== 1'b1 || winner !== 2'd0 || matriz !== EMPTY) begin
      missCount++; $display("[TB] FAIL timeout_forfeit: over %b winner %0d board %h want 1 0 %h", game_over, winner, matriz, EMPTY);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; human_first = 1'b0;
    p_valid = 1'b0; p_coord = 4'd0; cpu_valid = 1'b0; cpu_coord = 4'd0;
    expBoard = EMPTY;
    test_reset;
    test_start;
    test_human_win;
    test_illegal;
    test_cpu_win;
    test_draw;
    test_ninth_win;
    test_start_override;
    test_reset_midgame;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
